// File: rtl/snake_pkg.sv
// Shared snake-game constants, scanner state encodings and requester port IDs.
package snake_pkg;

  localparam int unsigned XSIZE    = 48;
  localparam int unsigned YSIZE    = 64;
  localparam int unsigned MAX_SIZE = 20;
  localparam int unsigned CW       = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } scan_state_e;

  typedef enum logic {
    PORT_COLL = 1'b0,
    PORT_ITEM = 1'b1
  } port_e;

endpackage

// File: rtl/snake_body_scanner_if.sv
// Request/result bundle between the body scanner and its two requesters plus the body registers.
interface snake_body_scanner_if #(
  parameter int unsigned MAX_SIZE = snake_pkg::MAX_SIZE,
  parameter int unsigned CW       = snake_pkg::CW,
  parameter int unsigned SIZE_W   = 12,
  parameter int unsigned IDX_W    = 5
);

  logic [MAX_SIZE*CW-1:0] i_Body_x;
  logic [MAX_SIZE*CW-1:0] i_Body_y;
  logic [SIZE_W-1:0]      i_Size;
  logic                   i_Req0;
  logic [CW-1:0]          i_Qx0;
  logic [CW-1:0]          i_Qy0;
  logic                   i_Req1;
  logic [CW-1:0]          i_Qx1;
  logic [CW-1:0]          i_Qy1;
  logic                   o_Ack0;
  logic                   o_Ack1;
  logic                   o_Hit;
  logic [IDX_W-1:0]       o_HitIdx;
  logic                   o_Busy;
  logic                   o_Grant;

  modport master (
    output i_Body_x, i_Body_y, i_Size,
    output i_Req0, i_Qx0, i_Qy0,
    output i_Req1, i_Qx1, i_Qy1,
    input  o_Ack0, o_Ack1, o_Hit, o_HitIdx, o_Busy, o_Grant
  );

  modport slave (
    input  i_Body_x, i_Body_y, i_Size,
    input  i_Req0, i_Qx0, i_Qy0,
    input  i_Req1, i_Qx1, i_Qy1,
    output o_Ack0, o_Ack1, o_Hit, o_HitIdx, o_Busy, o_Grant
  );

endinterface

// File: rtl/snake_rr_arbiter.sv
// Two-way round-robin arbiter; the priority pointer moves only when a scan completes.
module snake_rr_arbiter
  import snake_pkg::*;
(
  input  logic  i_Clk,
  input  logic  i_Rst,
  input  logic  req0_i,
  input  logic  req1_i,
  input  logic  done_i,
  input  port_e done_port_i,
  output logic  valid_o,
  output port_e port_o
);

  // Port that wins a tie; after serving a port the other one is favoured.
  port_e prio_q;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      prio_q <= PORT_COLL;
    end else if (done_i) begin
      prio_q <= (done_port_i == PORT_COLL) ? PORT_ITEM : PORT_COLL;
    end
  end

  always_comb begin
    valid_o = req0_i | req1_i;
    port_o  = PORT_COLL;
    if (req0_i && req1_i) begin
      port_o = prio_q;
    end else if (req1_i) begin
      port_o = PORT_ITEM;
    end
  end

endmodule

// File: rtl/snake_body_scanner.sv
// Shared snake-body occupancy checker: snapshots the body on grant and scans one segment per cycle.
module snake_body_scanner
  import snake_pkg::*;
#(
  parameter int unsigned MAX_SIZE = snake_pkg::MAX_SIZE,
  parameter int unsigned CW       = snake_pkg::CW,
  parameter int unsigned SIZE_W   = 12,
  parameter int unsigned IDX_W    = 5
) (
  input logic                 i_Clk,
  input logic                 i_Rst,
  snake_body_scanner_if.slave bus
);

  localparam int unsigned NW = $clog2(MAX_SIZE + 1);

  scan_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       hitidx_q, hitidx_d;
  logic                   hit_q, hit_d;
  logic [NW-1:0]          n_q, n_d;
  logic [CW-1:0]          qx_q, qx_d, qy_q, qy_d;
  logic [MAX_SIZE*CW-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  port_e                  gnt_q, gnt_d;

  logic                   arb_valid;
  port_e                  arb_port;
  logic [NW-1:0]          scan_len;
  logic [CW-1:0]          seg_x, seg_y;
  logic                   seg_match, seg_last;

  snake_rr_arbiter u_arb (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .req0_i      (bus.i_Req0),
    .req1_i      (bus.i_Req1),
    .done_i      (state_q == DONE),
    .done_port_i (gnt_q),
    .valid_o     (arb_valid),
    .port_o      (arb_port)
  );

  // Collision checks skip the tail segment since it vacates on the same move.
  always_comb begin
    scan_len = '0;
    if (arb_port == PORT_COLL) begin
      if (bus.i_Size <= SIZE_W'(1)) begin
        scan_len = '0;
      end else if (bus.i_Size >= SIZE_W'(MAX_SIZE)) begin
        scan_len = NW'(MAX_SIZE - 1);
      end else begin
        scan_len = NW'(bus.i_Size - SIZE_W'(1));
      end
    end else begin
      if (bus.i_Size >= SIZE_W'(MAX_SIZE)) begin
        scan_len = NW'(MAX_SIZE);
      end else begin
        scan_len = NW'(bus.i_Size);
      end
    end
  end

  assign seg_x     = snap_x_q[int'(idx_q)*CW +: CW];
  assign seg_y     = snap_y_q[int'(idx_q)*CW +: CW];
  assign seg_match = (seg_x == qx_q) && (seg_y == qy_q);
  assign seg_last  = (NW'(idx_q) + NW'(1)) == n_q;

  // Hit/HitIdx change only on the edge entering DONE so they stay stable between acks.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    hitidx_d = hitidx_q;
    n_d      = n_q;
    qx_d     = qx_q;
    qy_d     = qy_q;
    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    gnt_d    = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d    = arb_port;
          qx_d     = (arb_port == PORT_ITEM) ? bus.i_Qx1 : bus.i_Qx0;
          qy_d     = (arb_port == PORT_ITEM) ? bus.i_Qy1 : bus.i_Qy0;
          snap_x_d = bus.i_Body_x;
          snap_y_d = bus.i_Body_y;
          n_d      = scan_len;
          idx_d    = '0;
          if (scan_len == '0) begin
            hit_d    = 1'b0;
            hitidx_d = '0;
            state_d  = DONE;
          end else begin
            state_d  = SCAN;
          end
        end
      end
      SCAN: begin
        if (seg_match) begin
          hit_d    = 1'b1;
          hitidx_d = idx_q;
          state_d  = DONE;
        end else if (seg_last) begin
          hit_d    = 1'b0;
          hitidx_d = '0;
          state_d  = DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      hitidx_q <= '0;
      n_q      <= '0;
      qx_q     <= '0;
      qy_q     <= '0;
      snap_x_q <= '0;
      snap_y_q <= '0;
      gnt_q    <= PORT_COLL;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      hitidx_q <= hitidx_d;
      n_q      <= n_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      snap_x_q <= snap_x_d;
      snap_y_q <= snap_y_d;
      gnt_q    <= gnt_d;
    end
  end

  assign bus.o_Ack0   = (state_q == DONE) && (gnt_q == PORT_COLL);
  assign bus.o_Ack1   = (state_q == DONE) && (gnt_q == PORT_ITEM);
  assign bus.o_Hit    = hit_q;
  assign bus.o_HitIdx = hitidx_q;
  assign bus.o_Busy   = (state_q != IDLE);
  assign bus.o_Grant  = gnt_q;

endmodule

// File: tb/tb_snake_body_scanner.sv
// Directed plus randomized checks of the body scanner against a plain-arithmetic reference model.
module tb_snake_body_scanner;

  localparam int MS = 20;
  localparam int CWB = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snake_body_scanner_if #(.MAX_SIZE(MS), .CW(CWB), .SIZE_W(12), .IDX_W(5)) bus ();

  snake_body_scanner #(.MAX_SIZE(MS), .CW(CWB), .SIZE_W(12), .IDX_W(5)) dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int mprio = 0;
  int size = 0;
  logic [5:0] bx [MS];
  logic [5:0] by [MS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: scan length from the size rules, then first matching segment in order.
  task automatic model(input int port, input int qx, input int qy,
                       output int n, output int hit, output int idx, output int lat);
    int k;
    if (port == 0) n = (size <= 1) ? 0 : ((size - 1 > MS - 1) ? MS - 1 : size - 1);
    else           n = (size > MS) ? MS : size;
    hit = 0; idx = 0; k = n;
    for (int i = 0; i < n; i++) begin
      if (hit == 0 && int'(bx[i]) == qx && int'(by[i]) == qy) begin
        hit = 1; idx = i; k = i + 1;
      end
    end
    lat = (n == 0) ? 1 : k + 1;
  endtask

  task automatic drive_body();
    for (int i = 0; i < MS; i++) begin
      bus.i_Body_x[i*CWB +: CWB] = bx[i];
      bus.i_Body_y[i*CWB +: CWB] = by[i];
    end
    bus.i_Size = 12'(size);
  endtask

  task automatic rand_body();
    for (int i = 0; i < MS; i++) begin
      bx[i] = 6'($urandom_range(0, 47));
      by[i] = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic set_query(input int port, input int qx, input int qy);
    if (port == 0) begin bus.i_Qx0 = 6'(qx); bus.i_Qy0 = 6'(qy); end
    else           begin bus.i_Qx1 = 6'(qx); bus.i_Qy1 = 6'(qy); end
  endtask

  task automatic do_req(input string tag, input int port, input int qx, input int qy,
                        input int mutate_at);
    int n, hit, idx, lat, cyc;
    bit got;
    model(port, qx, qy, n, hit, idx, lat);
    drive_body();
    set_query(port, qx, qy);
    if (port == 0) bus.i_Req0 = 1'b1; else bus.i_Req1 = 1'b1;
    got = 0; cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (cyc == 1) begin
        check({tag, ".busy"}, 32'(bus.o_Busy), 1);
        check({tag, ".grant"}, 32'(bus.o_Grant), 32'(port));
      end
      if (bus.o_Ack0 || bus.o_Ack1) got = 1;
      else if (cyc == mutate_at) begin
        bus.i_Body_x = ~bus.i_Body_x;
        bus.i_Body_y = bus.i_Body_y ^ {MS{6'h15}};
      end
    end
    bus.i_Req0 = 1'b0; bus.i_Req1 = 1'b0;
    check({tag, ".ack_seen"}, 32'(got), 1);
    check({tag, ".ack_port"}, {30'd0, bus.o_Ack1, bus.o_Ack0}, (port == 1) ? 2 : 1);
    check({tag, ".hit"}, 32'(bus.o_Hit), 32'(hit));
    check({tag, ".hitidx"}, 32'(bus.o_HitIdx), 32'(idx));
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    if (got) mprio = 1 - port;
    @(posedge clk); @(negedge clk);
    check({tag, ".ack_1cyc"}, {30'd0, bus.o_Ack1, bus.o_Ack0}, 0);
    check({tag, ".idle"}, 32'(bus.o_Busy), 0);
    drive_body();
  endtask

  task automatic do_tie(input string tag, input int qx0, input int qy0, input int qx1, input int qy1);
    int n0, h0, i0, l0, n1, h1, i1, l1, exp_p, cyc, acks;
    model(0, qx0, qy0, n0, h0, i0, l0);
    model(1, qx1, qy1, n1, h1, i1, l1);
    drive_body();
    set_query(0, qx0, qy0);
    set_query(1, qx1, qy1);
    bus.i_Req0 = 1'b1; bus.i_Req1 = 1'b1;
    exp_p = mprio; acks = 0; cyc = 0;
    while (acks < 3 && cyc < 120) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (bus.o_Ack0 || bus.o_Ack1) begin
        check({tag, ".port"}, {30'd0, bus.o_Ack1, bus.o_Ack0}, (exp_p == 1) ? 2 : 1);
        check({tag, ".grant"}, 32'(bus.o_Grant), 32'(exp_p));
        check({tag, ".hit"}, 32'(bus.o_Hit), 32'((exp_p == 1) ? h1 : h0));
        check({tag, ".hitidx"}, 32'(bus.o_HitIdx), 32'((exp_p == 1) ? i1 : i0));
        acks++;
        exp_p = 1 - exp_p;
        if (acks == 3) begin bus.i_Req0 = 1'b0; bus.i_Req1 = 1'b0; end
      end
    end
    bus.i_Req0 = 1'b0; bus.i_Req1 = 1'b0;
    check({tag, ".acks"}, 32'(acks), 3);
    mprio = exp_p;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int qx, qy, port, j;
    rst_n = 1'b0;
    bus.i_Req0 = 1'b0; bus.i_Req1 = 1'b0;
    bus.i_Qx0 = '0; bus.i_Qy0 = '0; bus.i_Qx1 = '0; bus.i_Qy1 = '0;
    for (int i = 0; i < MS; i++) begin bx[i] = '0; by[i] = '0; end
    size = 0;
    drive_body();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.acks", {30'd0, bus.o_Ack1, bus.o_Ack0}, 0);
    check("rst.hit", 32'(bus.o_Hit), 0);
    check("rst.hitidx", 32'(bus.o_HitIdx), 0);
    check("rst.busy", 32'(bus.o_Busy), 0);
    check("rst.grant", 32'(bus.o_Grant), 0);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("idle.busy", 32'(bus.o_Busy), 0);
      check("idle.acks", {30'd0, bus.o_Ack1, bus.o_Ack0}, 0);
    end

    // Three-segment body along x=24.
    rand_body();
    bx[0] = 24; by[0] = 32; bx[1] = 24; by[1] = 33; bx[2] = 24; by[2] = 34;
    size = 3;
    do_req("coll_hit", 0, 24, 33, -1);
    do_req("item_miss", 1, 12, 32, -1);
    do_tie("tie", 24, 34, 24, 34);

    size = 1;
    do_req("size1", 0, 24, 32, -1);
    size = 0;
    do_req("size0_item", 1, 24, 32, -1);

    for (int i = 0; i < MS; i++) begin bx[i] = 6'(i); by[i] = 6'(i + 10); end
    size = 40;
    do_req("clip_item", 1, 19, 29, -1);
    do_req("clip_coll", 0, 19, 29, -1);

    bx[10] = 5; by[10] = 7;
    size = 20;
    do_req("snapshot", 1, 5, 7, 2);

    // Leave the pointer favouring port 1, then reset mid-scan.
    do_req("pre_rst", 0, 0, 10, -1);
    rand_body();
    size = 20;
    drive_body();
    set_query(1, 63, 63);
    bus.i_Req1 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(bus.o_Busy), 0);
    check("midrst.acks", {30'd0, bus.o_Ack1, bus.o_Ack0}, 0);
    bus.i_Req1 = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("midrst.noack", {30'd0, bus.o_Ack1, bus.o_Ack0}, 0);
    end
    rst_n = 1'b1;
    mprio = 0;
    @(posedge clk); @(negedge clk);
    check("postrst.noack", {30'd0, bus.o_Ack1, bus.o_Ack0}, 0);
    do_tie("postrst_tie", int'(bx[3]), int'(by[3]), 63, 0);

    for (int t = 0; t < 16; t++) begin
      rand_body();
      size = $urandom_range(0, 30);
      port = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, MS - 1);
        qx = int'(bx[j]); qy = int'(by[j]);
      end else begin
        qx = $urandom_range(0, 63); qy = $urandom_range(0, 63);
      end
      do_req("rand", port, qx, qy, ($urandom_range(0, 3) == 0) ? 3 : -1);
    end
    for (int t = 0; t < 3; t++) begin
      rand_body();
      size = $urandom_range(2, 24);
      j = $urandom_range(0, MS - 1);
      do_tie("rand_tie", int'(bx[j]), int'(by[j]), $urandom_range(0, 63), $urandom_range(0, 63));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
